pipe_stage_reg: RTL

Parametrised inter-stage pipeline register for the 5-stage MIPS core. It replaces the fixed-width, always-loading stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one configurable block. The block adds:
- a synchronous reset;
- a valid bit;
- stall (hold) and flush (bubble insert) control;
- control-field zeroing on bubbles;
- saturating stall and bubble counters for performance analysis.

One instance sits between each pair of adjacent stages.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_stage_reg.sv | 94 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS inter-stage pipeline registers: NOP encoding,
// per-boundary bundle widths and the downstream stage names used by tracing.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // IF/ID carries pc+4; ID/EX carries rd1, rd2, signimm, rt, rd.
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 32;
    localparam int IFID_CNT_W   = 16;
    localparam int IDEX_CTRL_W  = 9;
    localparam int IDEX_DATA_W  = 106;
    localparam int IDEX_CNT_W   = 16;
    localparam int EXMEM_CTRL_W = 3;
    localparam int EXMEM_DATA_W = 69;
    localparam int EXMEM_CNT_W  = 16;
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;
    localparam int MEMWB_CNT_W  = 16;

    localparam string IFID_NAME  = "ID";
    localparam string IDEX_NAME  = "EX";
    localparam string EXMEM_NAME = "MEM";
    localparam string MEMWB_NAME = "WB";

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}}))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// One-deep pipeline register with hold (stall), bubble insert (flush), ctrl
// zeroing on bubbles and saturating stall/bubble counters. PIPE_TRACE_EN adds a sim trace.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int    CTRL_W     = EXMEM_CTRL_W,
    parameter int    DATA_W     = EXMEM_DATA_W,
    parameter int    CNT_W      = EXMEM_CNT_W,
    parameter string STAGE_NAME = EXMEM_NAME
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [31:0]       instr_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [31:0]       instr_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [31:0]       instr_q, instr_d;
    logic              stall_inc, bubble_inc;

    // Flush beats stall; data is left alone on a flush since only ctrl can do harm.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            instr_d = NOP_INSTR;
        end else if (!stall) begin
            valid_d = valid_in;
            ctrl_d  = valid_in ? ctrl_in : '0;
            data_d  = data_in;
            instr_d = instr_in;
        end
    end

    assign stall_inc  = stall && !flush && valid_q;
    assign bubble_inc = flush || (!stall && !valid_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            instr_q <= instr_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    assign valid_out = valid_q;
    assign ctrl_out  = ctrl_q;
    assign data_out  = data_q;
    assign instr_out = instr_q;

`ifdef PIPE_TRACE_EN
    always @(posedge clk) begin
        if (!reset && valid_d)
            $display("Instruction %h is in %s stage", instr_d, STAGE_NAME);
    end
`endif

endmodule
